// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit packed BCD up/down counter with clear, parallel
// load (invalid digits clamped to 9), wrap or saturate at the limits,
// a one-cycle terminal-count pulse and a sticky overflow flag.
// Digit 0 is the least significant and occupies bits [3:0].
module bcd_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  zero
);

    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] dec_val;
    logic [4*DIGITS-1:0] clamp_val;
    logic                inc_cy;
    logic                dec_bw;

    // Ripple-carry BCD increment; inc_cy ends high only when every digit was 9.
    always_comb begin
        inc_val = count;
        inc_cy  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_cy) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    inc_cy            = 1'b0;
                end
            end
        end
    end

    // Ripple-borrow BCD decrement; dec_bw ends high only when every digit was 0.
    always_comb begin
        dec_val = count;
        dec_bw  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dec_bw) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    dec_bw            = 1'b0;
                end
            end
        end
    end

    // Clamp each load digit above 9 down to 9 so the count never holds a non-BCD digit.
    always_comb begin
        clamp_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            clamp_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Count, terminal-count and overflow registers; priority rst > clr > load > en.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= clamp_val;
            tc    <= 1'b0;
        end else if (en) begin
            if (up) begin
                tc <= inc_cy;
                if (inc_cy) ovf <= 1'b1;
                // In saturate mode a step past the limit leaves count where it is.
                if (WRAP || !inc_cy) count <= inc_val;
            end else begin
                tc <= dec_bw;
                if (dec_bw) ovf <= 1'b1;
                if (WRAP || !dec_bw) count <= dec_val;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    // Zero flag follows count combinationally.
    always_comb begin
        zero = (count == '0);
    end

endmodule
